// File: rtl/spu32_cpu_regfile_arbiter.sv
// Shares one spu32_cpu_registers instance between the CPU core and the debug unit.
// Optional starvation guard for debug requests: define SPU32_REGARB_STARVE_EN.
module spu32_cpu_regfile_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_core_req,
  input  logic        I_core_we,
  input  logic [4:0]  I_core_rs1,
  input  logic [4:0]  I_core_rs2,
  input  logic [4:0]  I_core_rd,
  input  logic [31:0] I_core_data,
  output logic        O_core_ack,
  output logic [31:0] O_core_regval1,
  output logic [31:0] O_core_regval2,
  input  logic        I_dbg_req,
  input  logic        I_dbg_we,
  input  logic [4:0]  I_dbg_addr,
  input  logic [31:0] I_dbg_data,
  output logic        O_dbg_ack,
  output logic [31:0] O_dbg_regval,
  output logic [4:0]  O_rf_rs1,
  output logic [4:0]  O_rf_rs2,
  output logic [4:0]  O_rf_rd,
  output logic [31:0] O_rf_data,
  output logic        O_rf_re,
  output logic        O_rf_we,
  input  logic [31:0] I_rf_regval1,
  input  logic [31:0] I_rf_regval2
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_ACK
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_grant_core;
  logic        w_grant_dbg;
  logic        w_force_dbg;
  logic        r_owner_dbg;
  logic        r_we;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [4:0]  r_rd;
  logic [31:0] r_data;
  logic [31:0] r_core_val1;
  logic [31:0] r_core_val2;
  logic [31:0] r_dbg_val;

`ifdef SPU32_REGARB_STARVE_EN
  logic [3:0] r_starve_cnt;

  assign w_force_dbg = (r_starve_cnt == 4'(STARVE_LIMIT));

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      r_starve_cnt <= 4'd0;
    end else if (r_state == S_IDLE) begin
      if (w_grant_dbg || !I_dbg_req)
        r_starve_cnt <= 4'd0;
      else if (w_grant_core && (r_starve_cnt != 4'(STARVE_LIMIT)))
        r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end
`else
  // Limit is always >= 1, so debug is never forced in: strict core priority.
  assign w_force_dbg = (STARVE_LIMIT == 0);
`endif

  always_comb begin
    w_grant_core = 1'b0;
    w_grant_dbg  = 1'b0;
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        w_grant_dbg  = I_dbg_req && (!I_core_req || w_force_dbg);
        w_grant_core = I_core_req && !w_grant_dbg;
        if (w_grant_core || w_grant_dbg)
          w_state_next = S_ISSUE;
      end
      S_ISSUE:   w_state_next = S_CAPTURE;
      S_CAPTURE: w_state_next = S_ACK;
      S_ACK:     w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      r_owner_dbg <= 1'b0;
      r_we        <= 1'b0;
      r_rs1       <= 5'd0;
      r_rs2       <= 5'd0;
      r_rd        <= 5'd0;
      r_data      <= 32'd0;
      r_core_val1 <= 32'd0;
      r_core_val2 <= 32'd0;
      r_dbg_val   <= 32'd0;
    end else begin
      if (w_grant_core) begin
        r_owner_dbg <= 1'b0;
        r_we        <= I_core_we;
        r_rs1       <= I_core_rs1;
        r_rs2       <= I_core_rs2;
        r_rd        <= I_core_rd;
        r_data      <= I_core_data;
      end else if (w_grant_dbg) begin
        r_owner_dbg <= 1'b1;
        r_we        <= I_dbg_we;
        r_rs1       <= I_dbg_addr;
        r_rs2       <= I_dbg_addr;
        r_rd        <= I_dbg_addr;
        r_data      <= I_dbg_data;
      end
      // Register-file read ports were loaded on the ISSUE edge and hold here.
      if (r_state == S_CAPTURE) begin
        if (r_owner_dbg) begin
          r_dbg_val <= I_rf_regval1;
        end else begin
          r_core_val1 <= I_rf_regval1;
          r_core_val2 <= I_rf_regval2;
        end
      end
    end
  end

  assign O_rf_rs1  = r_rs1;
  assign O_rf_rs2  = r_rs2;
  assign O_rf_rd   = r_rd;
  assign O_rf_data = r_data;
  assign O_rf_re   = (r_state == S_ISSUE) && !I_reset;
  assign O_rf_we   = (r_state == S_ISSUE) && r_we && (r_rd != 5'd0) && !I_reset;

  assign O_core_ack     = (r_state == S_ACK) && !r_owner_dbg && !I_reset;
  assign O_dbg_ack      = (r_state == S_ACK) && r_owner_dbg && !I_reset;
  assign O_core_regval1 = r_core_val1;
  assign O_core_regval2 = r_core_val2;
  assign O_dbg_regval   = r_dbg_val;

endmodule

// File: tb/tb_spu32_cpu_regfile_arbiter.sv
// Bench for spu32_cpu_regfile_arbiter: behavioural register file, array reference model,
// directed and random transactions checked with immediate assertions.
module tb_spu32_cpu_regfile_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we, dbg_req, dbg_we;
  logic [4:0]  core_rs1, core_rs2, core_rd, dbg_addr;
  logic [31:0] core_data, dbg_data;
  logic        core_ack, dbg_ack;
  logic [31:0] core_val1, core_val2, dbg_val;
  logic [4:0]  rf_rs1, rf_rs2, rf_rd;
  logic [31:0] rf_data;
  logic        rf_re, rf_we;
  logic [31:0] rf_v1 = 32'd0;
  logic [31:0] rf_v2 = 32'd0;
  logic [31:0] rf_mem [32] = '{default: 32'd0};
  int          x0_we_cnt = 0;

  int          n_vec = 0;
  int          n_fail = 0;
  logic [31:0] ref_mem [32] = '{default: 32'd0};
  logic [31:0] exp_c1 = 32'd0;
  logic [31:0] exp_c2 = 32'd0;
  logic [31:0] exp_d  = 32'd0;

  always #5 clk = ~clk;

  spu32_cpu_regfile_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .I_clk(clk), .I_reset(rst),
    .I_core_req(core_req), .I_core_we(core_we), .I_core_rs1(core_rs1), .I_core_rs2(core_rs2),
    .I_core_rd(core_rd), .I_core_data(core_data), .O_core_ack(core_ack),
    .O_core_regval1(core_val1), .O_core_regval2(core_val2),
    .I_dbg_req(dbg_req), .I_dbg_we(dbg_we), .I_dbg_addr(dbg_addr), .I_dbg_data(dbg_data),
    .O_dbg_ack(dbg_ack), .O_dbg_regval(dbg_val),
    .O_rf_rs1(rf_rs1), .O_rf_rs2(rf_rs2), .O_rf_rd(rf_rd), .O_rf_data(rf_data),
    .O_rf_re(rf_re), .O_rf_we(rf_we),
    .I_rf_regval1(rf_v1), .I_rf_regval2(rf_v2)
  );

  // Register file: reads load on re, write on we, x0 reads zero, reads see pre-write data.
  always @(posedge clk) begin
    if (rf_re) begin
      rf_v1 <= (rf_rs1 == 5'd0) ? 32'd0 : rf_mem[rf_rs1];
      rf_v2 <= (rf_rs2 == 5'd0) ? 32'd0 : rf_mem[rf_rs2];
    end
    if (rf_we) rf_mem[rf_rd] <= rf_data;
    if (rf_we && rf_rd == 5'd0) x0_we_cnt <= x0_we_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_ref(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'd0 : ref_mem[idx];
  endfunction

  task automatic core_txn(input logic we, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] data);
    int cyc = 0;
    core_we = we; core_rs1 = rs1; core_rs2 = rs2; core_rd = rd; core_data = data;
    core_req = 1'b1;
    do begin @(posedge clk); #1; cyc++; end while (core_ack !== 1'b1 && cyc < 12);
    core_req = 1'b0;
    check("core_ack_seen", 32'(core_ack), 32'd1);
    check("core_latency", 32'(cyc), 32'd3);
    check("core_no_dbg_ack", 32'(dbg_ack), 32'd0);
    exp_c1 = rd_ref(rs1);
    exp_c2 = rd_ref(rs2);
    if (we && rd != 5'd0) ref_mem[rd] = data;
    check("core_regval1", core_val1, exp_c1);
    check("core_regval2", core_val2, exp_c2);
    check("dbg_regval_kept", dbg_val, exp_d);
    @(posedge clk); #1;
    check("core_ack_pulse", 32'(core_ack), 32'd0);
  endtask

  task automatic dbg_txn(input logic we, input logic [4:0] addr, input logic [31:0] data);
    int cyc = 0;
    dbg_we = we; dbg_addr = addr; dbg_data = data;
    dbg_req = 1'b1;
    do begin @(posedge clk); #1; cyc++; end while (dbg_ack !== 1'b1 && cyc < 12);
    dbg_req = 1'b0;
    check("dbg_ack_seen", 32'(dbg_ack), 32'd1);
    check("dbg_latency", 32'(cyc), 32'd3);
    check("dbg_no_core_ack", 32'(core_ack), 32'd0);
    exp_d = rd_ref(addr);
    if (we && addr != 5'd0) ref_mem[addr] = data;
    check("dbg_regval", dbg_val, exp_d);
    check("core_regval1_kept", core_val1, exp_c1);
    check("core_regval2_kept", core_val2, exp_c2);
    @(posedge clk); #1;
    check("dbg_ack_pulse", 32'(dbg_ack), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_core_ack"}, 32'(core_ack), 32'd0);
    check({tag, "_dbg_ack"}, 32'(dbg_ack), 32'd0);
    check({tag, "_core_val1"}, core_val1, 32'd0);
    check({tag, "_core_val2"}, core_val2, 32'd0);
    check({tag, "_dbg_val"}, dbg_val, 32'd0);
    check({tag, "_rf_idx"}, {17'd0, rf_rs1, rf_rs2, rf_rd}, 32'd0);
    check({tag, "_rf_data"}, rf_data, 32'd0);
    check({tag, "_rf_strobes"}, {30'd0, rf_re, rf_we}, 32'd0);
  endtask

  initial begin
    int seq [10];
    int got;
    int cyc;
    int t_core;
    int t_dbg;
    logic ack_seen;

    rst = 1'b1;
    core_req = 1'b0; core_we = 1'b0; core_rs1 = 5'd0; core_rs2 = 5'd0; core_rd = 5'd0;
    core_data = 32'd0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 5'd0; dbg_data = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_all_zero("reset");

    // Core write then read back.
    core_txn(1'b1, 5'd1, 5'd1, 5'd1, 32'hBEEF);
    core_txn(1'b0, 5'd0, 5'd1, 5'd0, 32'd0);
    check("core_read_beef", core_val2, 32'hBEEF);

    // Write to x0 is suppressed.
    core_txn(1'b1, 5'd1, 5'd0, 5'd0, 32'hFEFE);
    core_txn(1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    check("x0_reads_zero", core_val1, 32'd0);
    check("x0_never_written", 32'(x0_we_cnt), 32'd0);

    // Debug write and read.
    dbg_txn(1'b1, 5'd5, 32'h1234);
    dbg_txn(1'b0, 5'd5, 32'd0);
    check("dbg_read_1234", dbg_val, 32'h1234);

    // Randomised single transactions.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0)
        core_txn(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), $urandom);
      else
        dbg_txn(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
    end
    check("rand_x0_never_written", 32'(x0_we_cnt), 32'd0);

    // Both requests held continuously: grant order.
    core_we = 1'b0; core_rs1 = 5'd1; core_rs2 = 5'd2; core_rd = 5'd0;
    dbg_we = 1'b0; dbg_addr = 5'd5;
    core_req = 1'b1; dbg_req = 1'b1;
    got = 0; cyc = 0;
    while (got < 10 && cyc < 80) begin
      @(posedge clk); #1; cyc++;
      if (core_ack === 1'b1) begin seq[got] = 0; got++; end
      else if (dbg_ack === 1'b1) begin seq[got] = 1; got++; end
    end
    core_req = 1'b0; dbg_req = 1'b0;
    check("held_grant_count", 32'(got), 32'd10);
    for (int k = 0; k < got; k++) begin
`ifdef SPU32_REGARB_STARVE_EN
      check($sformatf("grant_order_%0d", k), 32'(seq[k]), 32'((k % (LIMIT + 1)) == LIMIT));
`else
      check($sformatf("grant_order_%0d", k), 32'(seq[k]), 32'd0);
`endif
    end
    exp_c1 = rd_ref(5'd1);
    exp_c2 = rd_ref(5'd2);
`ifdef SPU32_REGARB_STARVE_EN
    exp_d = rd_ref(5'd5);
`endif
    repeat (2) begin @(posedge clk); #1; end
    check("held_core_val1", core_val1, exp_c1);
    check("held_core_val2", core_val2, exp_c2);
    check("held_dbg_val", dbg_val, exp_d);

    // Simultaneous rise from IDLE: core first, debug four cycles later.
    core_rs1 = 5'd2; core_rs2 = 5'd1; dbg_addr = 5'd1;
    core_req = 1'b1; dbg_req = 1'b1;
    t_core = -1; t_dbg = -1; cyc = 0;
    while ((t_core < 0 || t_dbg < 0) && cyc < 20) begin
      @(posedge clk); #1; cyc++;
      if (core_ack === 1'b1) begin t_core = cyc; core_req = 1'b0; end
      if (dbg_ack === 1'b1) begin t_dbg = cyc; dbg_req = 1'b0; end
    end
    core_req = 1'b0; dbg_req = 1'b0;
    check("race_core_ack_cycle", 32'(t_core), 32'd3);
    check("race_dbg_ack_cycle", 32'(t_dbg), 32'd7);
    exp_c1 = rd_ref(5'd2);
    exp_c2 = rd_ref(5'd1);
    exp_d  = rd_ref(5'd1);
    @(posedge clk); #1;
    check("race_core_val1", core_val1, exp_c1);
    check("race_dbg_val", dbg_val, exp_d);

    // Reset during ISSUE of a core write drops it.
    core_txn(1'b1, 5'd0, 5'd0, 5'd3, 32'h3333);
    core_we = 1'b1; core_rs1 = 5'd0; core_rs2 = 5'd0; core_rd = 5'd3; core_data = 32'hAAAA;
    core_req = 1'b1;
    @(posedge clk); #1;
    check("pre_reset_issue_we", 32'(rf_we), 32'd1);
    rst = 1'b1;
    #1;
    check("reset_issue_we", 32'(rf_we), 32'd0);
    check("reset_issue_re", 32'(rf_re), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; core_req = 1'b0;
    exp_c1 = 32'd0; exp_c2 = 32'd0; exp_d = 32'd0;
    check_all_zero("midreset");
    ack_seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (core_ack === 1'b1 || dbg_ack === 1'b1) ack_seen = 1'b1;
    end
    check("midreset_no_ack", 32'(ack_seen), 32'd0);
    core_txn(1'b0, 5'd3, 5'd0, 5'd0, 32'd0);
    check("x3_prior_value", core_val1, 32'h3333);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
